// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax row sequencer and its tag FIFO.
package softmax_pkg;

    localparam int SM_LATENCY = 10;
    localparam int SM_LANES   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sm_seq_state_t;

endpackage

// File: rtl/sm_tag_fifo.sv
// Synchronous tag FIFO holding the row index of every row in flight through the processor.
module sm_tag_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/softmax_row_sequencer.sv
// Streams tile rows from the score buffer into the softmax processor and steers
// the processor results back to the result buffer by row index.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | reading rows into the processor, one per unstalled cycle
// DRAIN | all rows issued, waiting for the last result
// DONE  | one-cycle completion pulse
module softmax_row_sequencer
    import softmax_pkg::*;
#(
    parameter int ROWS       = 16,
    parameter int ADDR_W     = 4,
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   row_count,
    input  logic              hold,
    output logic              busy,
    output logic              done,
    output logic              src_rd_en,
    output logic [ADDR_W-1:0] src_rd_addr,
    output logic              sm_valid_in,
    input  logic              sm_valid_out,
    output logic              dst_wr_en,
    output logic [ADDR_W-1:0] dst_wr_addr,
    output logic              err_orphan
);
    sm_seq_state_t           state_q, state_d;
    logic [ADDR_W:0]         row_cnt_q, row_cnt_d;
    logic [ADDR_W:0]         issue_cnt_q, issue_cnt_d;
    logic [ADDR_W:0]         retire_cnt_q, retire_cnt_d;
    logic                    rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]       rd_addr_q, rd_addr_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [RD_LATENCY-1:0]   vin_pipe_q, vin_pipe_d;

    logic                    accept;
    logic [ADDR_W:0]         row_lim;
    logic [ADDR_W:0]         issue_base;
    logic [ADDR_W:0]         issue_next;
    logic                    issue_window;
    logic                    push;
    logic                    pop;
    logic                    orphan;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [ADDR_W-1:0]       fifo_head;

    sm_tag_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (issue_base[ADDR_W-1:0]),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign accept  = (state_q == IDLE) && start;
    assign row_lim = (row_count > (ADDR_W+1)'(ROWS)) ? (ADDR_W+1)'(ROWS) : row_count;
    assign pop     = sm_valid_out && !fifo_empty;
    assign orphan  = sm_valid_out && fifo_empty;

    // The first row is issued from the start cycle so the read lands in cycle 1.
    assign issue_base   = accept ? '0 : issue_cnt_q;
    assign issue_next   = issue_base + (ADDR_W+1)'(1);
    assign issue_window = (accept && (row_lim != '0)) || (state_q == ISSUE);
    assign push         = issue_window && !hold && !fifo_full;

    always_comb begin
        state_d      = state_q;
        row_cnt_d    = row_cnt_q;
        issue_cnt_d  = issue_cnt_q;
        retire_cnt_d = retire_cnt_q + (ADDR_W+1)'(pop);
        err_d        = err_q | orphan;
        rd_en_d      = push;
        rd_addr_d    = push ? issue_base[ADDR_W-1:0] : '0;

        for (int i = 0; i < RD_LATENCY; i++) begin
            vin_pipe_d[i] = (i == 0) ? rd_en_q : vin_pipe_q[(i == 0) ? 0 : i - 1];
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    row_cnt_d    = row_lim;
                    err_d        = orphan;
                    retire_cnt_d = '0;
                    issue_cnt_d  = push ? issue_next : '0;
                    if (row_lim == '0) begin
                        state_d = DONE;
                    end else if (push && (issue_next == row_lim)) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (push) begin
                    issue_cnt_d = issue_next;
                    if (issue_next == row_cnt_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (retire_cnt_d >= row_cnt_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            row_cnt_q    <= '0;
            issue_cnt_q  <= '0;
            retire_cnt_q <= '0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            vin_pipe_q   <= '0;
        end else begin
            state_q      <= state_d;
            row_cnt_q    <= row_cnt_d;
            issue_cnt_q  <= issue_cnt_d;
            retire_cnt_q <= retire_cnt_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            vin_pipe_q   <= vin_pipe_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign src_rd_en   = rd_en_q;
    assign src_rd_addr = rd_addr_q;
    assign sm_valid_in = vin_pipe_q[RD_LATENCY-1];
    assign dst_wr_en   = pop;
    assign dst_wr_addr = fifo_head;
    assign err_orphan  = err_q;

endmodule
